trak_quad_counter: RTL and testbench
====================================

Name: trak_quad_counter

Overview:
- Receiving end of the trackball step interface. The top-level mouse emulator drives a per-axis {direction, step-toggle} pair; this block turns that pair back into per-axis up/down position counters.
- It matches the original cabinet's trackball counter hardware: a 4-bit count per axis plus a direction bit, latched for CPU reads.
- It sits between the top-level trackball generator and the game core's input mux. It replaces feeding raw toggles to the core.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each input bit (1..3).
- FILTER, 2, cycles a step-toggle change must stay stable before it is committed (0..15).
- CNT_W, 4, per-axis counter width (1..7).

Ports:
- clk_sys  in  1  system clock (12 MHz domain).
- reset  in  1  synchronous, active-high reset.
- trak_i  in  4  {x_dir, x_clk, y_dir, y_clk}. dir=1 means positive motion. Each toggle of clk is one step.
- flip_i  in  1  1 = invert both axis directions (cocktail flip). Sampled at commit.
- clear_i  in  1  synchronous clear of both counters.
- latch_i  in  1  snapshot both axes into the read registers.
- sel_i  in  1  read-byte select: 0 = X, 1 = Y.
- data_o  out  8  {snap_dir, zero-pad, snap_count[CNT_W-1:0]} of the selected axis. Combinational from the snapshot.
- x_count_o, y_count_o  out  CNT_W  live counters.
- x_dir_o, y_dir_o  out  1  direction of the last committed step (after flip).
- x_step_o, y_step_o  out  1  one-cycle pulse per committed step.

Behaviour:
- Synchronizers: all four trak_i bits pass through SYNC_STAGES flops. All later logic uses only the synced values.
- Per-axis FSM has three states: PRIME, IDLE and QUAL. Each axis holds ref (last accepted clk level) and fcnt (4-bit).
- PRIME: entered on reset.
  - Stays until SYNC_STAGES cycles have elapsed after reset deasserts.
  - Then loads ref from synced clk and goes to IDLE.
  - No step is ever counted from the power-up level.
- IDLE:
  - synced clk == ref: stay.
  - synced clk != ref with FILTER=0: commit immediately.
  - synced clk != ref with FILTER>0: fcnt <= FILTER-1 and go to QUAL.
- QUAL:
  - synced clk == ref (glitch): return to IDLE, no count.
  - fcnt==0: commit and return to IDLE.
  - otherwise: fcnt--.
- Commit:
  - ref <= synced clk.
  - eff_dir = synced dir XOR flip_i.
  - count <= count+1 if eff_dir, else count-1. Arithmetic is modulo 2^CNT_W: 0-1 gives all-ones, all-ones+1 gives 0.
  - dir_o <= eff_dir; step_o pulses for 1 cycle.
- Latency: a trak_i clk edge at cycle t updates count_o at t+SYNC_STAGES+FILTER+1. At defaults that is t+5.
- Toggles faster than FILTER+1 cycles apart are dropped as glitches. The generator steps at most once per clk_sys cycle, so FILTER=0 is required for full-rate tracking. Defaults are for noisy external inputs.
- clear_i: both counters go to 0 next cycle. FSM, ref and dir_o are unaffected.
  - clear_i and a commit in the same cycle: clear wins and the step is lost. step_o still pulses and dir_o still updates.
- latch_i: the snapshot takes the pre-edge counters and dir_o values.
  - latch_i and a commit in the same cycle: the snapshot holds the pre-commit value.
  - latch_i and clear_i in the same cycle: the snapshot holds the pre-clear value.
- data_o bit 7 is snap_dir. Bits CNT_W-1..0 are snap_count. All other bits are 0. data_o changes only on a latch or a sel_i change.
- Reset values:
  - counters, snapshots, dir_o, step_o, data_o: 0.
  - fcnt: 0. Sync flops: 0.
  - FSM: PRIME.
  - Reset mid-QUAL abandons the pending step.
- X and Y are fully independent. Simultaneous commits on both axes are both applied.

Test Plan:
- Reset release, trak_i=4'b0101 held static → PRIME absorbs the levels. After 20 cycles x_count_o=0, y_count_o=0, no step pulses.
- Defaults, x_dir=1, toggle x_clk 6 times, 10 cycles apart → x_count_o=6, x_dir_o=1, exactly 6 x_step_o pulses. The first count change lands 5 cycles after the first toggle.
- x_dir=0 from count 0, 3 toggles → x_count_o=4'hD. Repeat with flip_i=1 → back to 0, x_dir_o=1.
- FILTER=2, x_clk pulse 1 cycle wide then 2 cycles wide → no count. Then a 3-cycle-wide stable change → +1.
- Y at count 4'hF, commit +1 with latch_i in the same cycle, sel_i=1 → data_o=8'h8F (pre-commit) and y_count_o=0. A later latch gives data_o=8'h80.
- x_count_o=7, clear_i coincident with a commit → x_count_o=0 and one x_step_o pulse. FILTER=0, toggle every cycle for 16 cycles → x_count_o=0 (wrap), 16 pulses.

Source files
------------

// File: rtl/trak_quad_counter.sv
// rtl/trak_quad_counter.sv - trackball step/direction to per-axis up/down position counters

// One axis: edge qualification of the synced step toggle and the up/down counter
module trak_quad_axis #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             i_clk_s,
  input  logic             i_dir_s,
  input  logic             i_flip,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count,
  output logic             o_dir,
  output logic             o_step
);

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_IDLE  = 2'd1,
    ST_QUAL  = 2'd2
  } state_t;

  // PRIME waits this many cycles so the synchronizer holds real input levels
  localparam logic [1:0] PRIME_LAST = 2'(SYNC_STAGES);
  localparam logic [3:0] FILT_M1    = 4'((FILTER > 0) ? FILTER - 1 : 0);

  state_t           r_state, w_state_nxt;
  logic             r_ref, w_ref_nxt;
  logic [3:0]       r_fcnt, w_fcnt_nxt;
  logic [1:0]       r_prime, w_prime_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_step;
  logic             w_commit;
  logic             w_eff_dir;

  // State register plus the counter, direction and step pulse
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= ST_PRIME;
      r_ref   <= 1'b0;
      r_fcnt  <= 4'd0;
      r_prime <= 2'd0;
      r_count <= '0;
      r_dir   <= 1'b0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ref   <= w_ref_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_prime <= w_prime_nxt;
      r_count <= w_count_nxt;
      r_dir   <= w_dir_nxt;
      r_step  <= w_commit;
    end
  end

  // Next-state: prime the reference level, then qualify each level change
  always_comb begin
    w_state_nxt = r_state;
    w_ref_nxt   = r_ref;
    w_fcnt_nxt  = r_fcnt;
    w_prime_nxt = r_prime;
    w_commit    = 1'b0;
    w_eff_dir   = i_dir_s ^ i_flip;
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;

    case (r_state)
      ST_PRIME: begin
        if (r_prime == PRIME_LAST) begin
          w_ref_nxt   = i_clk_s;
          w_state_nxt = ST_IDLE;
        end else begin
          w_prime_nxt = r_prime + 2'd1;
        end
      end
      ST_IDLE: begin
        if (i_clk_s != r_ref) begin
          if (FILTER == 0) begin
            w_commit = 1'b1;
          end else begin
            w_fcnt_nxt  = FILT_M1;
            w_state_nxt = ST_QUAL;
          end
        end
      end
      ST_QUAL: begin
        // A return to the reference level before the filter expires is a glitch
        if (i_clk_s == r_ref) begin
          w_state_nxt = ST_IDLE;
        end else if (r_fcnt == 4'd0) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_fcnt_nxt = r_fcnt - 4'd1;
        end
      end
      default: w_state_nxt = ST_PRIME;
    endcase

    if (w_commit) begin
      w_ref_nxt   = i_clk_s;
      w_dir_nxt   = w_eff_dir;
      w_count_nxt = w_eff_dir ? (r_count + 1'b1) : (r_count - 1'b1);
    end

    // Clear beats a coincident commit; the step pulse and direction still update
    if (i_clear) begin
      w_count_nxt = '0;
    end
  end

  assign o_count = r_count;
  assign o_dir   = r_dir;
  assign o_step  = r_step;

endmodule

module trak_quad_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [3:0]       trak_i,
  input  logic             flip_i,
  input  logic             clear_i,
  input  logic             latch_i,
  input  logic             sel_i,
  output logic [7:0]       data_o,
  output logic [CNT_W-1:0] x_count_o,
  output logic [CNT_W-1:0] y_count_o,
  output logic             x_dir_o,
  output logic             y_dir_o,
  output logic             x_step_o,
  output logic             y_step_o
);

  logic [3:0]       r_sync [SYNC_STAGES];
  logic [3:0]       w_trak_s;
  logic [CNT_W-1:0] r_snap_x_cnt, r_snap_y_cnt;
  logic             r_snap_x_dir, r_snap_y_dir;
  logic [7:0]       w_data;

  // Input synchronizer chain on all four trackball bits
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= 4'd0;
      end
    end else begin
      r_sync[0] <= trak_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_trak_s = r_sync[SYNC_STAGES-1];

  trak_quad_axis #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER      (FILTER),
    .CNT_W       (CNT_W)
  ) u_x (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_clk_s (w_trak_s[2]),
    .i_dir_s (w_trak_s[3]),
    .i_flip  (flip_i),
    .i_clear (clear_i),
    .o_count (x_count_o),
    .o_dir   (x_dir_o),
    .o_step  (x_step_o)
  );

  trak_quad_axis #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER      (FILTER),
    .CNT_W       (CNT_W)
  ) u_y (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_clk_s (w_trak_s[0]),
    .i_dir_s (w_trak_s[1]),
    .i_flip  (flip_i),
    .i_clear (clear_i),
    .o_count (y_count_o),
    .o_dir   (y_dir_o),
    .o_step  (y_step_o)
  );

  // Read snapshot captures the pre-edge counters, so it never sees a same-cycle commit or clear
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_snap_x_cnt <= '0;
      r_snap_y_cnt <= '0;
      r_snap_x_dir <= 1'b0;
      r_snap_y_dir <= 1'b0;
    end else if (latch_i) begin
      r_snap_x_cnt <= x_count_o;
      r_snap_y_cnt <= y_count_o;
      r_snap_x_dir <= x_dir_o;
      r_snap_y_dir <= y_dir_o;
    end
  end

  // Read byte: direction in bit 7, count in the low bits, zero between
  always_comb begin
    w_data = 8'd0;
    if (sel_i) begin
      w_data[7]         = r_snap_y_dir;
      w_data[CNT_W-1:0] = r_snap_y_cnt;
    end else begin
      w_data[7]         = r_snap_x_dir;
      w_data[CNT_W-1:0] = r_snap_x_cnt;
    end
  end

  assign data_o = w_data;

endmodule

// File: tb/tb_trak_quad_counter.sv
// tb/tb_trak_quad_counter.sv - directed self-checking bench for trak_quad_counter
`timescale 1ns/1ps

module tb_trak_quad_counter;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [3:0] trak, trak0;
  logic       flip, clear, latch, sel;

  logic [7:0] data_o, data0_o;
  logic [3:0] x_count, y_count, x_count0, y_count0;
  logic       x_dir, y_dir, x_step, y_step;
  logic       x_dir0, y_dir0, x_step0, y_step0;

  int n_vec = 0;
  int n_bad = 0;
  int xp = 0, yp = 0, xp0 = 0;
  int base;

  always #5 clk_sys = ~clk_sys;

  trak_quad_counter u_dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .trak_i    (trak),
    .flip_i    (flip),
    .clear_i   (clear),
    .latch_i   (latch),
    .sel_i     (sel),
    .data_o    (data_o),
    .x_count_o (x_count),
    .y_count_o (y_count),
    .x_dir_o   (x_dir),
    .y_dir_o   (y_dir),
    .x_step_o  (x_step),
    .y_step_o  (y_step)
  );

  trak_quad_counter #(.FILTER(0)) u_dut0 (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .trak_i    (trak0),
    .flip_i    (flip),
    .clear_i   (clear),
    .latch_i   (latch),
    .sel_i     (sel),
    .data_o    (data0_o),
    .x_count_o (x_count0),
    .y_count_o (y_count0),
    .x_dir_o   (x_dir0),
    .y_dir_o   (y_dir0),
    .x_step_o  (x_step0),
    .y_step_o  (y_step0)
  );

  // Step pulse tallies, sampled just after each active edge
  always begin
    @(posedge clk_sys);
    #1;
    if (x_step)  xp  = xp + 1;
    if (y_step)  yp  = yp + 1;
    if (x_step0) xp0 = xp0 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic tog_x();
    trak[2] = ~trak[2];
  endtask

  task automatic tog_y();
    trak[0] = ~trak[0];
  endtask

  initial begin
    reset = 1'b1;
    trak  = 4'b0101;
    trak0 = 4'b0000;
    flip  = 1'b0;
    clear = 1'b0;
    latch = 1'b0;
    sel   = 1'b0;
    tick(3);
    chk("rst_x_count", x_count, 0);
    chk("rst_y_count", y_count, 0);
    chk("rst_data", data_o, 8'h00);
    chk("rst_x_dir", x_dir, 0);

    // Static levels after reset release must not count
    reset = 1'b0;
    base = xp + yp;
    tick(20);
    chk("prime_x", x_count, 0);
    chk("prime_y", y_count, 0);
    chk("prime_pulses", xp + yp - base, 0);

    // Six positive steps, first one checked for latency
    trak[3] = 1'b1;
    tick(10);
    base = xp;
    for (int i = 0; i < 6; i++) begin
      tog_x();
      tick(4);
      if (i == 0) chk("lat_before", x_count, 0);
      tick(1);
      chk("x_up", x_count, i + 1);
      tick(5);
    end
    chk("x_up_dir", x_dir, 1);
    chk("x_up_pulses", xp - base, 6);
    chk("y_untouched", y_count, 0);

    // Clear, then count down from zero, then flip back up
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clr_x", x_count, 0);
    trak[3] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tog_x();
      tick(10);
    end
    chk("x_down", x_count, 4'hD);
    chk("x_down_dir", x_dir, 0);
    flip = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tog_x();
      tick(10);
    end
    chk("x_flip", x_count, 0);
    chk("x_flip_dir", x_dir, 1);

    // Glitch filter: 1- and 2-cycle pulses dropped, 3-cycle pulse gives two steps
    base = xp;
    tog_x(); tick(1); tog_x(); tick(10);
    tog_x(); tick(2); tog_x(); tick(10);
    chk("glitch_count", x_count, 0);
    chk("glitch_pulses", xp - base, 0);
    tog_x(); tick(3); tog_x(); tick(10);
    chk("w3_count", x_count, 2);
    chk("w3_pulses", xp - base, 2);

    // Y: bring to F with dir 1, then wrap while latching
    flip = 1'b0;
    trak[1] = 1'b0;
    tog_y(); tick(10);
    tog_y(); tick(10);
    chk("y_e", y_count, 4'hE);
    trak[1] = 1'b1;
    tog_y(); tick(10);
    chk("y_f", y_count, 4'hF);
    sel = 1'b1;
    tog_y();
    tick(4);
    latch = 1'b1;
    tick(1);
    latch = 1'b0;
    chk("y_wrap", y_count, 0);
    chk("latch_pre", data_o, 8'h8F);
    tick(3);
    latch = 1'b1;
    tick(1);
    latch = 1'b0;
    chk("latch_post", data_o, 8'h80);
    sel = 1'b0;
    tick(1);
    chk("latch_x", data_o, 8'h82);

    // X to 7, then a down step coincident with clear
    trak[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tog_x();
      tick(10);
    end
    chk("x_seven", x_count, 7);
    trak[3] = 1'b0;
    tick(5);
    base = xp;
    tog_x();
    tick(4);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clr_commit_cnt", x_count, 0);
    chk("clr_commit_dir", x_dir, 0);
    chk("clr_commit_pulse", xp - base, 1);
    tick(5);
    chk("clr_commit_hold", x_count, 0);

    // FILTER=0 instance: toggle every cycle for 16 cycles
    trak0[3] = 1'b1;
    tick(5);
    base = xp0;
    for (int i = 0; i < 16; i++) begin
      if (i == 10) chk("f0_mid", x_count0, 8);
      trak0[2] = ~trak0[2];
      tick(1);
    end
    tick(5);
    chk("f0_wrap", x_count0, 0);
    chk("f0_pulses", xp0 - base, 16);
    chk("f0_dir", x_dir0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
